alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sequencing one shared sequential ALU
// Grants one requester at a time, strobes the ALU once, and routes the accepted result back to the owner.
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4
) (
   input  logic                          i_clk,
   input  logic                          i_nrst,
   input  logic [N_REQ-1:0]              i_req_valid,
   input  logic [2*N_REQ-1:0]            i_req_op,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_a,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_b,
   output logic [N_REQ-1:0]              o_req_grant,
   output logic [N_REQ-1:0]              o_rsp_valid,
   output logic [DATA_WIDTH-1:0]         o_rsp_q,
   output logic                          o_rsp_ovf,
   output logic                          o_busy,
   output logic [DATA_WIDTH-1:0]         o_alu_a,
   output logic [DATA_WIDTH-1:0]         o_alu_b,
   output logic                          o_alu_add,
   output logic                          o_alu_sub,
   output logic                          o_alu_mul,
   output logic                          o_alu_div,
   input  logic [DATA_WIDTH-1:0]         i_alu_q,
   input  logic                          i_alu_ovf,
   input  logic                          i_alu_accept
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [PW-1:0]           ptr;
   logic [PW-1:0]           owner;
   logic [PW-1:0]           winner;
   logic                    found;
   logic                    take;
   logic [1:0]              sel_op;
   logic [DATA_WIDTH-1:0]   sel_a;
   logic [DATA_WIDTH-1:0]   sel_b;

   // Scan ptr, ptr+1, ... with wrap at N_REQ; first valid index wins.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && i_req_valid[PW'(idx)]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (PW'(k) == winner) begin
            sel_op = i_req_op[2*k +: 2];
            sel_a  = i_req_a[k*DATA_WIDTH +: DATA_WIDTH];
            sel_b  = i_req_b[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      take        = 1'b0;
      o_req_grant = '0;
      case (state)
         IDLE: begin
            if (found) begin
               take                = 1'b1;
               o_req_grant[winner] = 1'b1;
               state_nxt           = ISSUE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (i_alu_accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_busy = (state != IDLE);

   // The four strobe flops double as the captured op: they load one-hot at grant and clear after ISSUE.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ptr         <= '0;
         owner       <= '0;
         o_alu_a     <= '0;
         o_alu_b     <= '0;
         o_alu_add   <= 1'b0;
         o_alu_sub   <= 1'b0;
         o_alu_mul   <= 1'b0;
         o_alu_div   <= 1'b0;
         o_rsp_valid <= '0;
         o_rsp_q     <= '0;
         o_rsp_ovf   <= 1'b0;
      end else begin
         o_rsp_valid <= '0;
         o_alu_add   <= 1'b0;
         o_alu_sub   <= 1'b0;
         o_alu_mul   <= 1'b0;
         o_alu_div   <= 1'b0;
         if (take) begin
            o_alu_a   <= sel_a;
            o_alu_b   <= sel_b;
            owner     <= winner;
            ptr       <= (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;
            o_alu_add <= (sel_op == 2'b00);
            o_alu_sub <= (sel_op == 2'b01);
            o_alu_mul <= (sel_op == 2'b10);
            o_alu_div <= (sel_op == 2'b11);
         end
         if (state == WAIT && i_alu_accept) begin
            o_rsp_valid[owner] <= 1'b1;
            o_rsp_q            <= i_alu_q;
            o_rsp_ovf          <= i_alu_ovf;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - bench for alu_share_arbiter with an emulated sequential ALU
// A transaction-level model predicts every output each cycle; literal expectations pin the model.
module tb_alu_share_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            nrst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [2*N-1:0]  req_op = '0;
   logic [N*DW-1:0] req_a = '0;
   logic [N*DW-1:0] req_b = '0;
   logic [N-1:0]    req_grant;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_q;
   logic            rsp_ovf;
   logic            busy;
   logic [DW-1:0]   alu_a, alu_b;
   logic            alu_add, alu_sub, alu_mul, alu_div;
   logic [DW-1:0]   alu_q;
   logic            alu_ovf;
   logic            alu_accept;
   int              alu_cnt;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
      .i_clk(clk), .i_nrst(nrst),
      .i_req_valid(req_valid), .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
      .o_req_grant(req_grant), .o_rsp_valid(rsp_valid), .o_rsp_q(rsp_q), .o_rsp_ovf(rsp_ovf),
      .o_busy(busy), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .o_alu_add(alu_add), .o_alu_sub(alu_sub), .o_alu_mul(alu_mul), .o_alu_div(alu_div),
      .i_alu_q(alu_q), .i_alu_ovf(alu_ovf), .i_alu_accept(alu_accept)
   );

   // Signed reference ALU: returns {ovf, q}.
   function automatic logic [8:0] alu_ref(input int op, input logic [7:0] a, input logic [7:0] b);
      int sa, sb, r;
      logic ovf;
      sa = $signed(a);
      sb = $signed(b);
      ovf = 1'b0;
      case (op)
         0: r = sa + sb;
         1: r = sa - sb;
         2: r = sa * sb;
         default: begin
            if (sb == 0) begin r = 0; ovf = 1'b1; end
            else r = sa / sb;
         end
      endcase
      if (r > 127 || r < -128) ovf = 1'b1;
      return {ovf, 8'(r)};
   endfunction

   // Emulated ALU: add/sub accept the cycle after the strobe, mul/div four cycles later.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         alu_accept <= 1'b0;
         alu_cnt    <= 0;
         alu_q      <= '0;
         alu_ovf    <= 1'b0;
      end else begin
         alu_accept <= 1'b0;
         if (alu_add || alu_sub) begin
            {alu_ovf, alu_q} <= alu_ref(alu_add ? 0 : 1, alu_a, alu_b);
            alu_accept       <= 1'b1;
         end else if (alu_mul || alu_div) begin
            {alu_ovf, alu_q} <= alu_ref(alu_mul ? 2 : 3, alu_a, alu_b);
            alu_cnt          <= 4;
         end else if (alu_cnt == 1) begin
            alu_accept <= 1'b1;
            alu_cnt    <= 0;
         end else if (alu_cnt > 1) begin
            alu_cnt <= alu_cnt - 1;
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   logic         rv[N];
   logic         persist[N];
   logic [1:0]   rop[N];
   logic [DW-1:0] ra[N];
   logic [DW-1:0] rb[N];

   bit            m_active = 0;
   int            m_age = 0;
   int            m_ptr = 0;
   int            m_owner = 0;
   int            m_op = 0;
   logic [DW-1:0] m_a = '0;
   logic [DW-1:0] m_b = '0;
   logic [8:0]    m_res = '0;
   bit            m_rsp_pend = 0;
   int            m_rsp_owner = 0;
   logic [DW-1:0] m_rsp_q = '0;
   logic          m_rsp_ovf = 1'b0;
   int            m_strobe_n = 0;

   int g_w[$];
   int g_c[$];
   int r_o[$];
   int r_q[$];
   int r_v[$];
   int r_c[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         req_valid[k]       = rv[k];
         req_op[2*k +: 2]   = rop[k];
         req_a[k*DW +: DW]  = ra[k];
         req_b[k*DW +: DW]  = rb[k];
      end
   endtask

   task automatic clr_logs();
      g_w.delete(); g_c.delete();
      r_o.delete(); r_q.delete(); r_v.delete(); r_c.delete();
      m_strobe_n = 0;
   endtask

   // One clock: compare DUT against the model at the falling edge, then advance the model.
   task automatic tick();
      logic [N-1:0] eg, ev, gnow;
      logic [3:0]   es;
      int w, k;
      drive();
      @(negedge clk);
      eg = '0; ev = '0; es = '0; gnow = '0; w = -1;
      if (!nrst) begin
         m_active = 0; m_age = 0; m_ptr = 0; m_owner = 0;
         m_a = '0; m_b = '0;
         m_rsp_pend = 0; m_rsp_q = '0; m_rsp_ovf = 1'b0;
      end else if (!m_active) begin
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (w < 0 && rv[k]) w = k;
         end
      end
      if (w >= 0) eg = N'(1) << w;
      if (m_active && m_age == 1) es = 4'b0001 << m_op;
      if (m_rsp_pend) ev = N'(1) << m_rsp_owner;
      check("grant", 32'(req_grant), 32'(eg));
      check("busy", 32'(busy), 32'(m_active));
      check("strobes", 32'({alu_div, alu_mul, alu_sub, alu_add}), 32'(es));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (m_rsp_pend || !nrst) begin
         check("rsp_q", 32'(rsp_q), 32'(m_rsp_q));
         check("rsp_ovf", 32'(rsp_ovf), 32'(m_rsp_ovf));
      end
      if (es != 0) m_strobe_n++;
      if (m_rsp_pend) begin
         r_o.push_back(m_rsp_owner); r_q.push_back(int'(m_rsp_q));
         r_v.push_back(int'(m_rsp_ovf)); r_c.push_back(cyc);
      end
      m_rsp_pend = 0;
      if (nrst) begin
         if (m_active) begin
            if (m_age >= 2 && alu_accept) begin
               m_rsp_pend = 1;
               m_rsp_owner = m_owner;
               {m_rsp_ovf, m_rsp_q} = m_res;
               m_active = 0;
            end else begin
               m_age++;
            end
         end else if (w >= 0) begin
            m_active = 1; m_age = 1; m_owner = w;
            m_op = int'(rop[w]); m_a = ra[w]; m_b = rb[w];
            m_res = alu_ref(m_op, ra[w], rb[w]);
            m_ptr = (w + 1) % N;
            g_w.push_back(w); g_c.push_back(cyc);
            gnow[w] = 1'b1;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) if (gnow[j] && !persist[j]) rv[j] = 1'b0;
   endtask

   task automatic run_until(input int n, input int maxc, input string tag);
      int c;
      c = 0;
      while (r_o.size() < n && c < maxc) begin
         tick();
         c++;
      end
      check({tag, "_rsp_count"}, 32'(r_o.size()), 32'(n));
   endtask

   task automatic set_req(input int k, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      rv[k] = 1'b1; rop[k] = op; ra[k] = a; rb[k] = b;
   endtask

   task automatic do_reset();
      for (int k = 0; k < N; k++) begin rv[k] = 1'b0; persist[k] = 1'b0; end
      nrst = 1'b0;
      tick(); tick();
      nrst = 1'b1;
      tick();
      clr_logs();
   endtask

   initial begin
      int exp_w[6];
      int c;
      for (int k = 0; k < N; k++) begin
         rv[k] = 1'b0; persist[k] = 1'b0; rop[k] = '0; ra[k] = '0; rb[k] = '0;
      end
      do_reset();

      // single add
      set_req(0, 2'b00, 8'd5, 8'd7);
      run_until(1, 20, "single");
      check("single_winner", 32'(g_w[0]), 32'd0);
      check("single_latency", 32'(r_c[0] - g_c[0]), 32'd3);
      check("single_owner", 32'(r_o[0]), 32'd0);
      check("single_q", 32'(r_q[0]), 32'd12);
      check("single_ovf", 32'(r_v[0]), 32'd0);
      check("single_strobe_cycles", 32'(m_strobe_n), 32'd1);
      tick(); tick();

      // all four contend from reset
      do_reset();
      set_req(0, 2'b00, 8'd1, 8'd2);
      set_req(1, 2'b01, 8'd10, 8'd20);
      set_req(2, 2'b00, 8'd50, 8'd60);
      set_req(3, 2'b00, 8'd100, 8'd27);
      run_until(4, 40, "contend");
      for (int i = 0; i < 4; i++) begin
         check("contend_order", 32'(g_w[i]), 32'(i));
         check("contend_owner", 32'(r_o[i]), 32'(i));
      end
      check("contend_q0", 32'(r_q[0]), 32'h03);
      check("contend_q1", 32'(r_q[1]), 32'hF6);
      check("contend_q2", 32'(r_q[2]), 32'h6E);
      check("contend_q3", 32'(r_q[3]), 32'h7F);
      check("contend_spacing", 32'(g_c[1] - g_c[0]), 32'd3);

      // fairness: req0 and req2 always valid
      do_reset();
      set_req(0, 2'b00, 8'd3, 8'd4);
      set_req(2, 2'b01, 8'd9, 8'd1);
      persist[0] = 1'b1; persist[2] = 1'b1;
      run_until(6, 60, "fair");
      exp_w = '{0, 2, 0, 2, 0, 2};
      for (int i = 0; i < 6; i++) check("fair_order", 32'(g_w[i]), 32'(exp_w[i]));
      check("fair_q_req2", 32'(r_q[1]), 32'd8);
      persist[0] = 1'b0; persist[2] = 1'b0; rv[0] = 1'b0; rv[2] = 1'b0;
      run_until(7, 20, "fair_drain");

      // signed mul then div
      do_reset();
      set_req(1, 2'b10, 8'hFD, 8'd4);
      run_until(1, 30, "mul");
      set_req(3, 2'b11, 8'd100, 8'd7);
      run_until(2, 30, "div");
      check("mul_owner", 32'(r_o[0]), 32'd1);
      check("mul_q", 32'(r_q[0]), 32'hF4);
      check("mul_ovf", 32'(r_v[0]), 32'd0);
      check("mul_latency", 32'(r_c[0] - g_c[0]), 32'd7);
      check("div_owner", 32'(r_o[1]), 32'd3);
      check("div_q", 32'(r_q[1]), 32'd14);

      // overflow on add and sub
      clr_logs();
      set_req(2, 2'b00, 8'd127, 8'd1);
      set_req(0, 2'b01, 8'd0, 8'h80);
      run_until(2, 30, "ovf");
      check("ovf_sub_owner", 32'(r_o[0]), 32'd0);
      check("ovf_sub_q", 32'(r_q[0]), 32'h80);
      check("ovf_sub_flag", 32'(r_v[0]), 32'd1);
      check("ovf_add_owner", 32'(r_o[1]), 32'd2);
      check("ovf_add_q", 32'(r_q[1]), 32'h80);
      check("ovf_add_flag", 32'(r_v[1]), 32'd1);

      // reset in the middle of a mul
      tick();
      clr_logs();
      set_req(0, 2'b10, 8'd3, 8'd5);
      c = 0;
      while (!(m_active && m_age >= 2) && c < 20) begin tick(); c++; end
      check("mul_reached_wait", 32'(m_active && m_age >= 2), 32'd1);
      tick();
      nrst = 1'b0;
      tick(); tick();
      nrst = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("reset_dropped_rsp", 32'(r_o.size()), 32'd0);
      clr_logs();
      set_req(0, 2'b00, 8'd2, 8'd2);
      set_req(1, 2'b00, 8'd1, 8'd1);
      run_until(2, 30, "post_reset");
      check("post_reset_winner", 32'(g_w[0]), 32'd0);
      check("post_reset_q", 32'(r_q[0]), 32'd4);
      check("post_reset_second", 32'(g_w[1]), 32'd1);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
